// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the IF-stage fetch unit
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'd19;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_perf_counters.sv
// rtl/fetch_perf_counters.sv - wrapping fetch and miss-cycle counters (FETCH_PERF_CNT_EN)
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        miss_inc_i,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_miss_cyc_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] miss_cyc_q, miss_cyc_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    miss_cyc_d  = miss_cyc_q;
    if (fetch_inc_i) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (miss_inc_i)  miss_cyc_d  = miss_cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      miss_cyc_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      miss_cyc_q  <= miss_cyc_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_miss_cyc_o  = miss_cyc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF-stage PC owner and instruction fetch FSM
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb,
  input  logic [31:0] jb_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] current_pc_out,
  output logic [31:0] inst_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_miss_cyc,
`endif
  output logic        stall_cache
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  tgt_aligned;
  logic         unused_tgt_lsb;

  assign tgt_aligned    = {jb_target[31:2], 2'b00};
  assign unused_tgt_lsb = &{1'b0, jb_target[1:0]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    unique case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (jb) begin
          if (imem_ready) begin
            pc_d = tgt_aligned;
          end else begin
            redir_pc_d = tgt_aligned;
            state_d    = S_DROP;
          end
        end else if (!stall && imem_ready) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      S_DROP: begin
        // The outstanding request must complete before the redirect is issued.
        if (jb) redir_pc_d = tgt_aligned;
        if (imem_ready) begin
          pc_d    = jb ? tgt_aligned : redir_pc_q;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req       = 1'b0;
    imem_addr      = pc_q;
    current_pc_out = 32'd0;
    inst_out       = NOP_INST;
    stall_cache    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        imem_req       = 1'b1;
        current_pc_out = pc_q;
        inst_out       = imem_ready ? imem_rdata : NOP_INST;
        stall_cache    = ~imem_ready;
      end
      S_DROP:  imem_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      redir_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk              (clk),
    .rst              (rst),
    .fetch_inc_i      ((state_q == S_RUN) && imem_ready && !jb && !stall),
    .miss_inc_i       (stall_cache),
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_miss_cyc_o  (perf_miss_cyc)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'd19;

  logic        clk = 1'b0;
  logic        rst, stall, jb, imem_ready;
  logic [31:0] jb_target, imem_rdata;
  logic        imem_req, stall_cache;
  logic [31:0] imem_addr, current_pc_out, inst_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_miss_cyc;
`endif

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        sc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .jb             (jb),
    .jb_target      (jb_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .current_pc_out (current_pc_out),
    .inst_out       (inst_out),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_miss_cyc  (perf_miss_cyc),
`endif
    .stall_cache    (stall_cache)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs after negedge, push expectation, pop and compare 1ns later.
  task automatic step(input string tag, input logic r, input logic s, input logic j,
                      input logic [31:0] tgt, input logic rdy,
                      input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                      input logic e_data, input logic e_sc);
    exp_t e, got;
    @(negedge clk);
    rst        = r;
    stall      = s;
    jb         = j;
    jb_target  = tgt;
    imem_ready = rdy;
    imem_rdata = 32'hDEAD_0000 ^ e_addr;
    e.req  = e_req;
    e.addr = e_addr;
    e.pc   = e_pc;
    e.inst = e_data ? (32'hDEAD_0000 ^ e_addr) : NOP;
    e.sc   = e_sc;
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    check32({tag, ".req"}, {31'd0, imem_req}, {31'd0, got.req});
    if (got.req) check32({tag, ".addr"}, imem_addr, got.addr);
    check32({tag, ".pc"}, current_pc_out, got.pc);
    check32({tag, ".inst"}, inst_out, got.inst);
    check32({tag, ".sc"}, {31'd0, stall_cache}, {31'd0, got.sc});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jb = 1'b0; jb_target = '0; imem_ready = 1'b1; imem_rdata = '0;
    repeat (2) @(posedge clk);

    // reset release: one idle cycle, then sequential fetch with hits
    step("idle",   0,0,0,0,1, 0, 32'h0,  32'h0,  0, 0);
    step("seq0",   0,0,0,0,1, 1, 32'h0,  32'h0,  1, 0);
    step("seq4",   0,0,0,0,1, 1, 32'h4,  32'h4,  1, 0);
    step("seq8",   0,0,0,0,1, 1, 32'h8,  32'h8,  1, 0);
    step("seqC",   0,0,0,0,1, 1, 32'hC,  32'hC,  1, 0);
    // three-cycle miss at 0x10
    step("miss1",  0,0,0,0,0, 1, 32'h10, 32'h10, 0, 1);
    step("miss2",  0,0,0,0,0, 1, 32'h10, 32'h10, 0, 1);
    step("miss3",  0,0,0,0,0, 1, 32'h10, 32'h10, 0, 1);
    step("hit10",  0,0,0,0,1, 1, 32'h10, 32'h10, 1, 0);
    step("seq14",  0,0,0,0,1, 1, 32'h14, 32'h14, 1, 0);
    step("seq18",  0,0,0,0,1, 1, 32'h18, 32'h18, 1, 0);
    step("seq1C",  0,0,0,0,1, 1, 32'h1C, 32'h1C, 1, 0);
    // jump with hit, misaligned target
    step("jb20",   0,0,1,32'h103,1, 1, 32'h20,  32'h20,  1, 0);
    step("jbtgt",  0,0,1,32'h40, 1, 1, 32'h100, 32'h100, 1, 0);
    // jump during miss, second jump in DROP, stall ignored in DROP
    step("jbmiss", 0,0,1,32'h200,0, 1, 32'h40, 32'h40, 0, 1);
    step("drop1",  0,0,1,32'h300,0, 1, 32'h40, 32'h0,  0, 0);
    step("drop2",  0,1,0,32'h0,  0, 1, 32'h40, 32'h0,  0, 0);
    step("drop3",  0,1,0,32'h0,  1, 1, 32'h40, 32'h0,  0, 0);
    step("redir",  0,0,1,32'h80, 1, 1, 32'h300, 32'h300, 1, 0);
    // hazard stall holds pc, then jb+stall redirects
    step("stl1",   0,1,0,32'h0,  1, 1, 32'h80, 32'h80, 1, 0);
    step("stl2",   0,1,0,32'h0,  1, 1, 32'h80, 32'h80, 1, 0);
    step("stl3",   0,0,0,32'h0,  1, 1, 32'h80, 32'h80, 1, 0);
    step("jbstl",  0,1,1,32'h400,1, 1, 32'h84, 32'h84, 1, 0);
    step("seq400", 0,0,0,32'h0,  1, 1, 32'h400, 32'h400, 1, 0);
    // jb coinciding with ready in DROP takes the live target
    step("jbm2",   0,0,1,32'h500,0, 1, 32'h404, 32'h404, 0, 1);
    step("dropjb", 0,0,1,32'h604,1, 1, 32'h404, 32'h0,   0, 0);
    step("jbwrap", 0,0,1,32'hFFFF_FFFC,1, 1, 32'h604, 32'h604, 1, 0);
    step("top",    0,0,0,32'h0,  1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
    step("wrap0",  0,0,0,32'h0,  1, 1, 32'h0, 32'h0, 1, 0);
    // reset during a miss
    step("miss4",  0,0,0,32'h0,  0, 1, 32'h4, 32'h4, 0, 1);
    step("rstm",   1,0,0,32'h0,  0, 1, 32'h4, 32'h4, 0, 1);
    step("ridle",  0,0,0,32'h0,  1, 0, 32'h0, 32'h0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    check32("perf_fetch", perf_fetch_cnt, 32'd0);
    check32("perf_miss",  perf_miss_cyc,  32'd0);
`endif
    step("rrun",   0,0,0,32'h0,  1, 1, 32'h0, 32'h0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
